// File: rtl/motion_segment_sequencer.sv
// motion_segment_sequencer
//
// Splits a signed relative move into segments of at most SEG_MAX steps and
// hands them to a motor controller one at a time. The controller is told a
// segment length on stepsToGo while this block waits in LOAD. It then reports
// that it is busy on activeMode. The sequencer keeps stepsToGo at zero while
// the controller runs, so the controller cannot restart on a stale length.
//
// Parameters
//   SEG_MAX        maximum steps per issued segment (1..4095)
//   START_TIMEOUT  LOAD cycles to wait for activeMode before flagging an error
//
// Ports
//   CLK, reset     clock (rising edge) and asynchronous active-high reset
//   cmdValid/Ready command handshake; cmdSteps (signed) and cmdDivider
//   abort          stop issuing further segments
//   stepsToGo      segment length to controller (nonzero only in LOAD)
//   divider        step period to controller, held for the whole move
//   dirInput       direction to controller, 1 = negative move
//   activeMode     busy flag from controller
//   busy           sequencer not idle
//   done           one-cycle pulse at move completion, abort or timeout
//   timeoutErr     sticky; cleared by the next accepted command
//   position       signed accumulated position (wraps modulo 2^19)
//
// Build option
//   MOTION_SEQ_POSITION_EN  when defined, position is tracked; otherwise
//                           position is tied to zero.
module motion_segment_sequencer #(
  parameter logic [11:0] SEG_MAX       = 12'hFFF,
  parameter int unsigned START_TIMEOUT = 1023
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        cmdValid,
  output logic        cmdReady,
  input  logic [18:0] cmdSteps,
  input  logic [14:0] cmdDivider,
  input  logic        abort,
  output logic [11:0] stepsToGo,
  output logic [14:0] divider,
  output logic        dirInput,
  input  logic        activeMode,
  output logic        busy,
  output logic        done,
  output logic        timeoutErr,
  output logic [18:0] position
);

  localparam int unsigned TW = $clog2(START_TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StNext} state_e;

  state_e        state_q, state_d;
  logic [18:0]   remaining_q, remaining_d;
  logic [11:0]   seg_q, seg_d;
  logic [14:0]   divider_q, divider_d;
  logic          dir_q, dir_d;
  logic [TW-1:0] wait_q, wait_d;
  logic          done_q, done_d;
  logic          terr_q, terr_d;

  logic          accept;
  logic [18:0]   cmd_mag;
  logic [11:0]   seg_next;
  logic          load_timeout;

  assign accept       = cmdValid & cmdReady;
  // Magnitude as 19-bit unsigned: the most negative input maps to 2^18.
  assign cmd_mag      = cmdSteps[18] ? (~cmdSteps + 19'd1) : cmdSteps;
  assign seg_next     = (remaining_q > {7'd0, SEG_MAX}) ? SEG_MAX : remaining_q[11:0];
  // The counter starts at 0 on LOAD entry, so this fires on the
  // START_TIMEOUT-th LOAD clock edge.
  assign load_timeout = (wait_q == TW'(START_TIMEOUT - 1));

  // State register
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StNext;
      StNext: state_d = (remaining_q == '0) ? StIdle : StLoad;
      StLoad: begin
        if (activeMode) begin
          state_d = StRun;
        end else if (abort || load_timeout) begin
          state_d = StIdle;
        end
      end
      StRun:  if (!activeMode) state_d = StNext;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state
  always_comb begin
    remaining_d = remaining_q;
    seg_d       = seg_q;
    divider_d   = divider_q;
    dir_d       = dir_q;
    wait_d      = wait_q;
    done_d      = 1'b0;
    terr_d      = terr_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          remaining_d = cmd_mag;
          divider_d   = cmdDivider;
          dir_d       = cmdSteps[18];
          terr_d      = 1'b0;
        end
      end
      StNext: begin
        if (remaining_q == '0) begin
          done_d = 1'b1;
        end else begin
          seg_d  = seg_next;
          wait_d = '0;
        end
      end
      StLoad: begin
        if (activeMode) begin
          // The controller has started, so this segment will run even when
          // abort arrives in the same cycle; only the rest is dropped.
          remaining_d = abort ? '0 : remaining_q - {7'd0, seg_q};
        end else if (abort) begin
          remaining_d = '0;
          done_d      = 1'b1;
        end else if (load_timeout) begin
          remaining_d = '0;
          done_d      = 1'b1;
          terr_d      = 1'b1;
        end else begin
          wait_d = wait_q + TW'(1);
        end
      end
      StRun: begin
        if (abort) remaining_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      remaining_q <= '0;
      seg_q       <= '0;
      divider_q   <= '0;
      dir_q       <= 1'b0;
      wait_q      <= '0;
      done_q      <= 1'b0;
      terr_q      <= 1'b0;
    end else begin
      remaining_q <= remaining_d;
      seg_q       <= seg_d;
      divider_q   <= divider_d;
      dir_q       <= dir_d;
      wait_q      <= wait_d;
      done_q      <= done_d;
      terr_q      <= terr_d;
    end
  end

  // Outputs
  always_comb begin
    // Gated by done_q so that done and cmdReady are never high together. The
    // reset term keeps ready low while reset is held.
    cmdReady  = (state_q == StIdle) && !done_q && !reset;
    busy      = (state_q != StIdle);
    stepsToGo = (state_q == StLoad) ? seg_q : '0;
  end

  assign divider    = divider_q;
  assign dirInput   = dir_q;
  assign done       = done_q;
  assign timeoutErr = terr_q;

`ifdef MOTION_SEQ_POSITION_EN
  logic [18:0] pos_q, pos_d;

  // Credit the segment when the controller reports it has finished.
  always_comb begin
    pos_d = pos_q;
    if ((state_q == StRun) && !activeMode) begin
      pos_d = dir_q ? (pos_q - {7'd0, seg_q}) : (pos_q + {7'd0, seg_q});
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      pos_q <= '0;
    end else begin
      pos_q <= pos_d;
    end
  end

  assign position = pos_q;
`else
  assign position = '0;
`endif

endmodule

// File: tb/tb_motion_segment_sequencer.sv
module tb_motion_segment_sequencer;

  localparam int unsigned ToCycles = 300;

  logic        CLK = 1'b0;
  logic        reset;
  logic        cmdValid;
  logic        cmdReady;
  logic [18:0] cmdSteps;
  logic [14:0] cmdDivider;
  logic        abort;
  logic [11:0] stepsToGo;
  logic [14:0] divider;
  logic        dirInput;
  logic        activeMode;
  logic        busy;
  logic        done;
  logic        timeoutErr;
  logic [18:0] position;

  always #5 CLK = ~CLK;

  motion_segment_sequencer #(
    .SEG_MAX      (12'hFFF),
    .START_TIMEOUT(ToCycles)
  ) dut (
    .CLK       (CLK),
    .reset     (reset),
    .cmdValid  (cmdValid),
    .cmdReady  (cmdReady),
    .cmdSteps  (cmdSteps),
    .cmdDivider(cmdDivider),
    .abort     (abort),
    .stepsToGo (stepsToGo),
    .divider   (divider),
    .dirInput  (dirInput),
    .activeMode(activeMode),
    .busy      (busy),
    .done      (done),
    .timeoutErr(timeoutErr),
    .position  (position)
  );

  int total    = 0;
  int bad      = 0;
  int done_cnt = 0;
  int ctl_delay = 2;
  bit ctl_hold  = 1'b0;
  logic [11:0] sb_q[$];

  function automatic int pos_exp(input int v);
`ifdef MOTION_SEQ_POSITION_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (done === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, {31'd0, found}, 32'd1);
  endtask

  task automatic wait_active(input string tag, input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (activeMode === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    chk({tag, "_active_seen"}, {31'd0, found}, 32'd1);
  endtask

  // Drives one command; returns on the falling edge right after acceptance.
  task automatic send_cmd(input logic [18:0] s, input logic [14:0] d, input logic ab);
    for (int i = 0; i < 50 && cmdReady !== 1'b1; i++) @(negedge CLK);
    chk("ready_before_cmd", {31'd0, cmdReady}, 32'd1);
    cmdValid   = 1'b1;
    cmdSteps   = s;
    cmdDivider = d;
    abort      = ab;
    @(negedge CLK);
    cmdValid = 1'b0;
    abort    = 1'b0;
  endtask

  // done must never coincide with cmdReady.
  always @(negedge CLK) begin
    if (done === 1'b1) begin
      done_cnt++;
      chk("done_vs_ready", {31'd0, cmdReady}, 32'd0);
    end
  end

  // Motor controller model: takes a segment, starts after ctl_delay cycles,
  // runs for a few cycles. Each taken segment is checked against the scoreboard.
  initial begin : ctl
    logic [11:0] seg;
    logic [11:0] expv;
    activeMode = 1'b0;
    forever begin
      @(negedge CLK);
      if (!ctl_hold && reset === 1'b0 && stepsToGo != '0) begin
        seg = stepsToGo;
        if (sb_q.size() == 0) begin
          chk("unexpected_segment", {20'd0, seg}, 32'd0);
        end else begin
          expv = sb_q.pop_front();
          chk("segment_len", {20'd0, seg}, {20'd0, expv});
        end
        repeat (ctl_delay) @(negedge CLK);
        activeMode = 1'b1;
        repeat (4) @(negedge CLK);
        activeMode = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int d0;
    int n;
    reset      = 1'b1;
    cmdValid   = 1'b0;
    cmdSteps   = '0;
    cmdDivider = '0;
    abort      = 1'b0;
    repeat (3) @(negedge CLK);

    // Reset state
    chk("rst_ready", {31'd0, cmdReady}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_steps", {20'd0, stepsToGo}, 32'd0);
    chk("rst_divider", {17'd0, divider}, 32'd0);
    chk("rst_dir", {31'd0, dirInput}, 32'd0);
    chk("rst_terr", {31'd0, timeoutErr}, 32'd0);
    chk("rst_pos", {13'd0, position}, 32'd0);
    reset = 1'b0;
    @(negedge CLK);
    chk("ready_after_reset", {31'd0, cmdReady}, 32'd1);

    // +5000: two segments
    ctl_delay = 2;
    sb_q.push_back(12'd4095);
    sb_q.push_back(12'd905);
    d0 = done_cnt;
    send_cmd(19'd5000, 15'd100, 1'b0);
    chk("p5000_dir", {31'd0, dirInput}, 32'd0);
    chk("p5000_div", {17'd0, divider}, 32'd100);
    chk("p5000_busy", {31'd0, busy}, 32'd1);
    wait_done("p5000", 200);
    chk("p5000_div_hold", {17'd0, divider}, 32'd100);
    chk("p5000_pos", {13'd0, position}, pos_exp(5000));
    repeat (5) @(negedge CLK);
    chk("p5000_done_once", done_cnt - d0, 32'd1);
    chk("p5000_sb_empty", sb_q.size(), 32'd0);

    // -10, slow controller start, abort held during the accept cycle
    ctl_delay = 257;
    sb_q.push_back(12'd10);
    send_cmd(-19'sd10, 15'd7, 1'b1);
    chk("m10_dir", {31'd0, dirInput}, 32'd1);
    chk("m10_div", {17'd0, divider}, 32'd7);
    wait_done("m10", 600);
    chk("m10_terr", {31'd0, timeoutErr}, 32'd0);
    chk("m10_pos", {13'd0, position}, pos_exp(4990));
    chk("m10_sb_empty", sb_q.size(), 32'd0);
    ctl_delay = 2;

    // Zero-step command
    send_cmd(19'd0, 15'd9, 1'b0);
    chk("zero_done_early", {31'd0, done}, 32'd0);
    chk("zero_steps_a", {20'd0, stepsToGo}, 32'd0);
    @(negedge CLK);
    chk("zero_done_2cyc", {31'd0, done}, 32'd1);
    chk("zero_steps_b", {20'd0, stepsToGo}, 32'd0);
    @(negedge CLK);
    chk("zero_done_clr", {31'd0, done}, 32'd0);
    chk("zero_ready", {31'd0, cmdReady}, 32'd1);

    // Timeout: controller never starts
    ctl_hold = 1'b1;
    send_cmd(19'd20, 15'd3, 1'b0);
    @(negedge CLK);
    chk("to_seg", {20'd0, stepsToGo}, 32'd20);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      n++;
      if (done === 1'b1) break;
    end
    chk("to_latency", n, ToCycles);
    chk("to_terr", {31'd0, timeoutErr}, 32'd1);
    chk("to_steps", {20'd0, stepsToGo}, 32'd0);
    chk("to_busy", {31'd0, busy}, 32'd0);
    chk("to_pos", {13'd0, position}, pos_exp(4990));

    // Abort in LOAD without controller start
    send_cmd(19'd50, 15'd3, 1'b0);
    chk("abl_terr_clr", {31'd0, timeoutErr}, 32'd0);
    @(negedge CLK);
    chk("abl_seg", {20'd0, stepsToGo}, 32'd50);
    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    chk("abl_done", {31'd0, done}, 32'd1);
    chk("abl_terr", {31'd0, timeoutErr}, 32'd0);
    chk("abl_steps", {20'd0, stepsToGo}, 32'd0);
    chk("abl_busy", {31'd0, busy}, 32'd0);
    ctl_hold = 1'b0;
    @(negedge CLK);

    // Asynchronous reset in RUN
    sb_q.push_back(12'd4095);
    send_cmd(19'd9000, 15'd11, 1'b0);
    wait_active("rrun", 20);
    @(negedge CLK);
    chk("rrun_busy", {31'd0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rrun_ready", {31'd0, cmdReady}, 32'd0);
    chk("rrun_busy0", {31'd0, busy}, 32'd0);
    chk("rrun_done", {31'd0, done}, 32'd0);
    chk("rrun_steps", {20'd0, stepsToGo}, 32'd0);
    chk("rrun_div", {17'd0, divider}, 32'd0);
    chk("rrun_dir", {31'd0, dirInput}, 32'd0);
    chk("rrun_terr", {31'd0, timeoutErr}, 32'd0);
    chk("rrun_pos", {13'd0, position}, 32'd0);
    @(negedge CLK);
    reset = 1'b0;
    for (int i = 0; i < 10 && activeMode !== 1'b0; i++) @(negedge CLK);
    @(negedge CLK);
    chk("rrun_ready_after", {31'd0, cmdReady}, 32'd1);
    chk("rrun_sb_empty", sb_q.size(), 32'd0);

    // +9000 with abort during the first RUN: only one segment issued
    sb_q.push_back(12'd4095);
    send_cmd(19'd9000, 15'd11, 1'b0);
    wait_active("abr", 20);
    @(negedge CLK);
    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    chk("abr_busy", {31'd0, busy}, 32'd1);
    wait_done("abr", 50);
    chk("abr_pos", {13'd0, position}, pos_exp(4095));
    chk("abr_steps", {20'd0, stepsToGo}, 32'd0);
    repeat (10) @(negedge CLK);
    chk("abr_sb_empty", sb_q.size(), 32'd0);
    chk("abr_idle", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
